// File: rtl/lf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lf_pkg
// Description : Shared types and constants for the LF ADC sampling path.
//               Holds the sequencer state encoding, the divider floor and
//               the sample phase within the low half-period.
// Revision    : 1.0 - initial release
// ============================================================================
package lf_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TRIG = 2'd1,
        RUN       = 2'd2
    } lf_state_t;

    // Shortest allowed half-period is MIN_DIV+1 = 16 pck0 cycles, which
    // leaves room for a full 8-bit byte between consecutive sample points.
    localparam logic [7:0] MIN_DIV      = 8'd15;
    localparam logic [7:0] SAMPLE_PHASE = 8'd7;

    function automatic logic [7:0] clamp_div(input logic [7:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lf_ssp_ser.sv
`default_nettype none
// ============================================================================
// Module      : lf_ssp_ser
// Description : 8-bit load/shift serializer for the SSP link. A load
//               captures a byte; the following 8 cycles present it MSB
//               first on ssp_din, with ssp_frame marking the MSB cycle.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               load, data     - load strobe and byte to serialize
//               ssp_din        - serial data (0 when no byte in flight)
//               ssp_frame      - one-cycle frame marker aligned with MSB
// Revision    : 1.0 - initial release
// ============================================================================
module lf_ssp_ser (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ssp_din,
    output logic       ssp_frame
);

    logic [7:0] r_shreg;
    logic [3:0] r_bit_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg   <= 8'd0;
            r_bit_cnt <= 4'd0;
        end else if (load) begin
            r_shreg   <= data;
            r_bit_cnt <= 4'd8;
        end else if (r_bit_cnt != 4'd0) begin
            r_shreg   <= {r_shreg[6:0], 1'b0};
            r_bit_cnt <= r_bit_cnt - 4'd1;
        end
    end

    // Gating on the bit counter keeps the line quiet between bytes even
    // if stale data were left in the shift register.
    assign ssp_din   = (r_bit_cnt != 4'd0) & r_shreg[7];
    assign ssp_frame = (r_bit_cnt == 4'd8);

endmodule
`default_nettype wire

// File: rtl/lf_adc_sched.sv
`default_nettype none
// ============================================================================
// Module      : lf_adc_sched
// Description : LF ADC sampling sequencer. Divides pck0 into the ADC /
//               antenna half-period clock, optionally waits for an
//               amplitude trigger, decimates samples and hands kept bytes
//               to the SSP serializer.
// Ports       : pck0, rst            - clock, synchronous active-high reset
//               divisor              - half-period length - 1 (min 15)
//               decim                - decimation ratio - 1
//               trig_en, trig_level  - trigger arm enable and threshold
//               arm, stop            - single-cycle start / stop requests
//               lf_field, ssp_dout   - field enable, ARM modulation bit
//               adc_d                - ADC sample
//               adc_clk, pwr_lo      - ADC clock, antenna drive
//               ssp_din, ssp_frame   - serialized sample stream to ARM
//               busy, sample_cnt     - status: active, kept-sample count
// Revision    : 1.0 - initial release
// ============================================================================
module lf_adc_sched
    import lf_pkg::*;
#(
    parameter int DECIM_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic               pck0,
    input  logic               rst,
    input  logic [7:0]         divisor,
    input  logic [DECIM_W-1:0] decim,
    input  logic               trig_en,
    input  logic [7:0]         trig_level,
    input  logic               arm,
    input  logic               stop,
    input  logic               lf_field,
    input  logic               ssp_dout,
    input  logic [7:0]         adc_d,
    output logic               adc_clk,
    output logic               pwr_lo,
    output logic               ssp_din,
    output logic               ssp_frame,
    output logic               busy,
    output logic [CNT_W-1:0]   sample_cnt
);

    // ------------------------------------------------------------------
    // Half-period divider
    // ------------------------------------------------------------------
    logic [7:0] r_div_cnt;
    logic [7:0] r_eff_div;
    logic       r_clk_state;
    logic       r_adc_clk;
    logic       r_pwr_lo;
    logic       w_div_tc;
    logic       w_sample_pt;

    assign w_div_tc    = (r_div_cnt == r_eff_div);
    assign w_sample_pt = ~r_clk_state & (r_div_cnt == SAMPLE_PHASE);

    // eff_div is only re-latched at a half-period boundary so a divisor
    // change never produces a truncated or stretched half-period.
    always_ff @(posedge pck0) begin
        if (rst) begin
            r_div_cnt   <= 8'd0;
            r_eff_div   <= clamp_div(divisor);
            r_clk_state <= 1'b0;
            r_adc_clk   <= 1'b1;
            r_pwr_lo    <= 1'b0;
        end else begin
            r_pwr_lo <= lf_field & ~ssp_dout & r_clk_state;
            if (w_div_tc) begin
                r_div_cnt   <= 8'd0;
                r_clk_state <= ~r_clk_state;
                r_adc_clk   <= r_clk_state;
                r_eff_div   <= clamp_div(divisor);
            end else begin
                r_div_cnt <= r_div_cnt + 8'd1;
            end
        end
    end

    assign adc_clk = r_adc_clk;
    assign pwr_lo  = r_pwr_lo;

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    lf_state_t          r_state;
    lf_state_t          w_state_nxt;
    logic               w_start;
    logic               w_keep;
    logic               w_dec_step;
    logic [DECIM_W-1:0] r_dec_cnt;
    logic [CNT_W-1:0]   r_sample_cnt;

    always_ff @(posedge pck0) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // stop takes priority everywhere, including over a simultaneous arm
    // and over a sample point that would otherwise be kept.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_keep      = 1'b0;
        w_dec_step  = 1'b0;
        case (r_state)
            IDLE: begin
                if (arm && !stop) begin
                    w_start     = 1'b1;
                    w_state_nxt = trig_en ? WAIT_TRIG : RUN;
                end
            end
            WAIT_TRIG: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                end else if (w_sample_pt && (adc_d >= trig_level)) begin
                    w_keep      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                end else if (w_sample_pt) begin
                    if (r_dec_cnt == '0) begin
                        w_keep = 1'b1;
                    end else begin
                        w_dec_step = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // The trigger sample counts as a kept sample, so it also reloads the
    // decimation counter; the next kept sample is decim+1 points later.
    always_ff @(posedge pck0) begin
        if (rst) begin
            r_dec_cnt    <= '0;
            r_sample_cnt <= '0;
        end else if (w_start) begin
            r_dec_cnt    <= '0;
            r_sample_cnt <= '0;
        end else if (w_keep) begin
            r_dec_cnt    <= decim;
            r_sample_cnt <= r_sample_cnt + 1'b1;
        end else if (w_dec_step) begin
            r_dec_cnt <= r_dec_cnt - 1'b1;
        end
    end

    assign busy       = (r_state != IDLE);
    assign sample_cnt = r_sample_cnt;

    // ------------------------------------------------------------------
    // SSP serializer
    // ------------------------------------------------------------------
    lf_ssp_ser u_ser (
        .clk       (pck0),
        .rst       (rst),
        .load      (w_keep),
        .data      (adc_d),
        .ssp_din   (ssp_din),
        .ssp_frame (ssp_frame)
    );

endmodule
`default_nettype wire

// File: tb/tb_lf_adc_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_lf_adc_sched
// Description : Self-checking bench for lf_adc_sched. A cycle-level
//               reference model predicts clock, status and kept bytes;
//               kept bytes go into a queue that an independent monitor
//               drains as frames appear on the SSP outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lf_adc_sched;

    localparam int DECIM_W = 4;
    localparam int CNT_W   = 16;

    logic               pck0 = 1'b0;
    logic               rst = 1'b1;
    logic [7:0]         divisor = 8'd15;
    logic [DECIM_W-1:0] decim = '0;
    logic               trig_en = 1'b0;
    logic [7:0]         trig_level = 8'd0;
    logic               arm = 1'b0;
    logic               stop = 1'b0;
    logic               lf_field = 1'b0;
    logic               ssp_dout = 1'b0;
    logic [7:0]         adc_d = 8'd0;
    logic               adc_clk;
    logic               pwr_lo;
    logic               ssp_din;
    logic               ssp_frame;
    logic               busy;
    logic [CNT_W-1:0]   sample_cnt;

    lf_adc_sched #(.DECIM_W(DECIM_W), .CNT_W(CNT_W)) dut (
        .pck0       (pck0),
        .rst        (rst),
        .divisor    (divisor),
        .decim      (decim),
        .trig_en    (trig_en),
        .trig_level (trig_level),
        .arm        (arm),
        .stop       (stop),
        .lf_field   (lf_field),
        .ssp_dout   (ssp_dout),
        .adc_d      (adc_d),
        .adc_clk    (adc_clk),
        .pwr_lo     (pwr_lo),
        .ssp_din    (ssp_din),
        .ssp_frame  (ssp_frame),
        .busy       (busy),
        .sample_cnt (sample_cnt)
    );

    always #5 pck0 = ~pck0;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    function automatic int clampd(input int d);
        return (d < 15) ? 15 : d;
    endfunction

    // ------------------------------------------------------------------
    // Reference model (runs just after each rising edge)
    // ------------------------------------------------------------------
    bit         m_valid = 0;
    int         m_level, m_pos, m_half, m_mode, m_k, m_cnt, m_flush;
    bit         m_pwr, m_frame_exp;
    logic [7:0] exp_q[$];

    always @(posedge pck0) begin
        bit sp, keep;
        #1;
        if (rst) begin
            m_valid = 1; m_level = 0; m_pos = 0; m_half = clampd(divisor) + 1;
            m_mode = 0; m_k = 0; m_cnt = 0; m_pwr = 0; m_frame_exp = 0;
            m_flush = exp_q.size();
        end else if (m_valid) begin
            sp    = (m_level == 0) && (m_pos == 7);
            keep  = 0;
            m_pwr = lf_field & ~ssp_dout & (m_level != 0);
            case (m_mode)
                0: if (arm && !stop) begin
                       m_cnt = 0; m_k = 0; m_mode = trig_en ? 1 : 2;
                   end
                1: if (stop) m_mode = 0;
                   else if (sp && adc_d >= trig_level) begin
                       keep = 1; m_mode = 2; m_k = 1;
                   end
                default: if (stop) m_mode = 0;
                   else if (sp) begin
                       if (m_k % (decim + 1) == 0) keep = 1;
                       m_k++;
                   end
            endcase
            if (keep) begin
                exp_q.push_back(adc_d);
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end
            m_frame_exp = keep;
            if (m_pos == m_half - 1) begin
                m_pos = 0; m_level ^= 1; m_half = clampd(divisor) + 1;
            end else begin
                m_pos++;
            end
        end
        if (m_valid) begin
            check("adc_clk",    {31'd0, adc_clk}, (m_level == 0) ? 32'd1 : 32'd0);
            check("busy",       {31'd0, busy}, (m_mode != 0) ? 32'd1 : 32'd0);
            check("sample_cnt", {16'd0, sample_cnt}, m_cnt);
            check("pwr_lo",     {31'd0, pwr_lo}, {31'd0, m_pwr});
            check("ssp_frame",  {31'd0, ssp_frame}, {31'd0, m_frame_exp});
        end
    end

    // ------------------------------------------------------------------
    // Monitor: pops an expected byte at each frame and compares 8 bits
    // ------------------------------------------------------------------
    int         rd_idx = 0;
    bit         collecting = 0;
    int         nbits;
    logic [7:0] got, exp_byte;

    always @(posedge pck0) begin
        #2;
        if (m_valid) begin
            if (rst) begin
                collecting = 0;
                if (rd_idx < m_flush) rd_idx = m_flush;
                check("rst_din",   {31'd0, ssp_din}, 32'd0);
                check("rst_frame", {31'd0, ssp_frame}, 32'd0);
            end else if (ssp_frame) begin
                if (collecting) check("frame_mid_byte", {31'd0, ssp_frame}, 32'd0);
                if (rd_idx >= exp_q.size()) begin
                    check("frame_q_empty", {31'd0, ssp_frame}, 32'd0);
                    collecting = 0;
                end else begin
                    exp_byte   = exp_q[rd_idx];
                    rd_idx++;
                    collecting = 1;
                    nbits      = 1;
                    got        = {7'd0, ssp_din};
                end
            end else if (collecting) begin
                got = {got[6:0], ssp_din};
                nbits++;
                if (nbits == 8) begin
                    check("byte", {24'd0, got}, {24'd0, exp_byte});
                    collecting = 0;
                end
            end else begin
                check("idle_din", {31'd0, ssp_din}, 32'd0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus (inputs change on the falling edge)
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge pck0);
    endtask

    task automatic pulse_arm();
        arm = 1'b1; tick(1); arm = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(1); stop = 1'b0;
    endtask

    task automatic wait_frame();
        int t = 0;
        while (!ssp_frame && t < 300) begin
            tick(1);
            t++;
        end
        if (t >= 300) check("frame_timeout", {31'd0, ssp_frame}, 32'd1);
    endtask

    initial begin
        @(negedge pck0);
        rst = 1'b1; tick(3); rst = 1'b0;
        tick(60);

        // Immediate start, no decimation, constant byte
        adc_d = 8'hA5; decim = 0; trig_en = 0;
        pulse_arm();
        tick(110);
        pulse_stop();
        tick(40);

        // Decimation by 4 with random data
        decim = 4'd3;
        pulse_arm();
        for (int i = 0; i < 12 * 32; i++) begin
            adc_d = 8'($urandom); tick(1);
        end
        pulse_stop();
        tick(40);
        decim = 0;

        // Trigger on a rising ramp
        trig_en = 1; trig_level = 8'h80; adc_d = 8'h70;
        pulse_arm();
        tick(32); adc_d = 8'h7F;
        tick(32); adc_d = 8'h80;
        tick(64);
        pulse_stop();
        trig_en = 0;
        tick(40);

        // Divisor clamp and mid-half-period change
        divisor = 8'd4; tick(100);
        divisor = 8'd15; tick(40);
        divisor = 8'd31; tick(200);
        divisor = 8'd15; tick(70);

        // stop three cycles into a byte
        adc_d = 8'h3C;
        pulse_arm();
        wait_frame();
        tick(2);
        pulse_stop();
        tick(40);

        // reset three cycles into a byte
        adc_d = 8'hC3;
        pulse_arm();
        wait_frame();
        tick(3);
        rst = 1'b1; tick(1); rst = 1'b0;
        tick(40);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            adc_d    = 8'($urandom);
            lf_field = 1'($urandom);
            ssp_dout = 1'($urandom);
            arm      = ($urandom % 40) == 0;
            stop     = ($urandom % 200) == 0;
            if (($urandom % 100) == 0) divisor = 8'($urandom_range(0, 40));
            if (m_mode == 0 && ($urandom % 20) == 0) begin
                decim      = DECIM_W'($urandom);
                trig_en    = 1'($urandom);
                trig_level = 8'($urandom);
            end
            tick(1);
        end
        arm = 0; stop = 1; tick(1); stop = 0;
        tick(40);

        check("pending_bytes", rd_idx, exp_q.size());
        check("byte_in_flight", {31'd0, collecting}, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lf_adc_sched.md
Name: lf_adc_sched

Overview:
- Sequencer for the LF ADC sampling path.
- Generates the ADC/antenna half-period clock from pck0 using a programmable divisor.
- Optionally waits for an amplitude trigger, then decimates samples and serializes each kept byte to the ARM SSP port.
- Sits between the ADC/antenna drivers and the SSP link; the ARM configures it and consumes bytes.

Parameters:
- DECIM_W, 4, width of decimation ratio input (keep 1 of decim+1 samples)
- CNT_W, 16, width of the kept-sample counter

Ports:
- pck0  in  1  24 MHz clock, the only clock
- rst  in  1  synchronous, active-high reset
- divisor  in  8  half-period length minus 1 in pck0 cycles; values below 15 treated as 15
- decim  in  DECIM_W  decimation ratio minus 1
- trig_en  in  1  1 = arm waits for trigger; 0 = arm starts immediately
- trig_level  in  8  trigger threshold (unsigned)
- arm  in  1  single-cycle start request
- stop  in  1  single-cycle stop request
- lf_field  in  1  reader field enable
- ssp_dout  in  1  ARM modulation bit (1 = suppress field)
- adc_d  in  8  ADC sample
- adc_clk  out  1  ADC clock, inverse of internal clk_state
- pwr_lo  out  1  LF antenna drive
- ssp_din  out  1  serialized sample, MSB first
- ssp_frame  out  1  one-cycle frame marker aligned with MSB
- busy  out  1  high in WAIT_TRIG or RUN
- sample_cnt  out  CNT_W  kept samples since last arm, wraps

Behaviour:
- Reset state:
  - All outputs 0 except adc_clk = 1 (clk_state = 0).
  - FSM = IDLE; divider, decimation counter, shift register and sample_cnt all 0.
- Divider:
  - div_cnt counts 0..eff_div, where eff_div = max(divisor, 15).
  - At terminal count: div_cnt <= 0, clk_state toggles, and eff_div is re-latched.
  - A divisor change therefore takes effect only at a half-period boundary.
- adc_clk = ~clk_state, registered.
- pwr_lo = lf_field & ~ssp_dout & clk_state, registered (1-cycle latency).
- Sample point: clk_state == 0 and div_cnt == 7. adc_d is captured at this edge.
- FSM transitions:
  - IDLE: on arm, clear sample_cnt and load dec_cnt = 0; go to WAIT_TRIG if trig_en, else RUN.
  - WAIT_TRIG: at each sample point, if adc_d >= trig_level, go to RUN and keep that same sample (serialized, counted).
  - RUN: at each sample point, if dec_cnt == 0, keep the sample and reload dec_cnt = decim; otherwise decrement dec_cnt.
  - stop in WAIT_TRIG or RUN: go to IDLE. A byte already being shifted completes; no new byte is loaded.
  - stop and arm in the same cycle: stop wins.
  - arm outside IDLE: ignored.
- Serializer:
  - A kept sample loads shreg at the sample-point edge and sets bit_cnt = 8.
  - Next 8 cycles: ssp_din = shreg[7], shift left with zero fill, decrement bit_cnt.
  - ssp_frame = 1 only on the first of those cycles.
  - ssp_din = 0 whenever bit_cnt == 0.
  - Minimum half-period is 16 cycles, so a byte always completes before the next sample point; no overrun path exists.
- sample_cnt: +1 per kept sample, wraps at 2^CNT_W - 1 -> 0.
- busy: combinational decode of FSM != IDLE.
- rst mid-byte:
  - Frame aborts; ssp_din and ssp_frame are 0 in the cycle after rst.
  - Divider restarts at 0.

Decomposition:
- Shared package lf_pkg:
  - FSM state encoding: IDLE=2'd0, WAIT_TRIG=2'd1, RUN=2'd2.
  - MIN_DIV = 8'd15.
  - SAMPLE_PHASE = 8'd7.
- One natural sub-module: lf_ssp_ser, the 8-bit load/shift/frame serializer with bit counter, reusable by other LF modes.
- Divider and FSM stay in the top.

Test Plan:
- Reset release, divisor=15, no arm -> adc_clk toggles every 16 cycles starting at 1; ssp_frame never asserted; busy=0.
- trig_en=0, decim=0, arm, adc_d=8'hA5 -> frame one cycle after each sample point; ssp_din sequence 1,0,1,0,0,1,0,1; sample_cnt=1 after first byte.
- decim=3, 12 sample points -> exactly 3 frames (samples 0, 4, 8); sample_cnt=3.
- trig_en=1, trig_level=8'h80, adc_d ramps 8'h70, 8'h7F, 8'h80 -> no frame until the 8'h80 sample; that sample is serialized; busy=1 throughout.
- divisor=4 -> half-period is 16 cycles (clamped); divisor changed 15->31 mid half-period -> current half stays 16 cycles, next is 32.
- stop asserted 3 cycles into a byte -> remaining 5 bits still shifted, busy falls next cycle, no further frames; rst asserted mid-byte instead -> ssp_din=0 next cycle, sample_cnt=0.
